// File: rtl/pipe_ctrl_hazard_pkg.sv
// Shared types for the pipeline control / hazard block.
//   ctrl_t      : decoded control bits carried down the pipe
//   CTRL_BUBBLE : all-zero control word inserted on stall or flush
//   fwd_e       : ALU operand-source select encoding
package pipe_ctrl_pkg;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  // Unknown control bits enter the pipe as 0 so no X ever propagates.
  function automatic logic x_to_zero(input logic b);
    return (b === 1'b1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// Bus bundle between the decode stage and the control/hazard block.
//   slave  : view taken by pipe_ctrl_hazard (id_* / ex_branch_taken in, rest out)
//   master : view taken by the surrounding core or a testbench
interface pipe_ctrl_hazard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_branch, id_memread, id_memtoreg, id_memwrite;
  logic                  id_alusrc, id_regwrite;
  logic [1:0]            id_aluop;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic                  ex_branch_taken;

  logic                  pc_write, ifid_write, ifid_flush;

  logic [1:0]            ex_aluop;
  logic                  ex_alusrc, ex_branch, ex_memread, ex_memwrite;
  logic                  ex_memtoreg, ex_regwrite;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;

  logic                  mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic                  wb_memtoreg, wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic [1:0]            forward_a, forward_b;
  logic [CNT_W-1:0]      stall_count;

  modport slave (
    input  id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
           id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush,
           ex_aluop, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
           ex_regwrite, ex_rs1, ex_rs2, ex_rd,
           mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd,
           wb_memtoreg, wb_regwrite, wb_rd,
           forward_a, forward_b, stall_count
  );

  modport master (
    output id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
           id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush,
           ex_aluop, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
           ex_regwrite, ex_rs1, ex_rs2, ex_rd,
           mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd,
           wb_memtoreg, wb_regwrite, wb_rd,
           forward_a, forward_b, stall_count
  );
endinterface

// File: rtl/pipe_ctrl_hazard_forward_unit.sv
// Combinational forwarding select for the two ALU operands in EX.
//   i_mem_regwrite/i_mem_rd : writer in EX/MEM (highest priority)
//   i_wb_regwrite/i_wb_rd   : writer in MEM/WB
//   i_ex_rs1/i_ex_rs2       : source registers of the instruction in EX
//   o_forward_a/o_forward_b : FWD_MEM, FWD_WB or FWD_NONE
module forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  output fwd_e                  o_forward_a,
  output fwd_e                  o_forward_b
);

  // Newer result (MEM) wins over older (WB); x0 is never a forwarding source.
  function automatic fwd_e pick(input logic mrw, input logic [REG_ADDR_W-1:0] mrd,
                                input logic wrw, input logic [REG_ADDR_W-1:0] wrd,
                                input logic [REG_ADDR_W-1:0] rs);
    if (mrw && (mrd != '0) && (mrd == rs)) return FWD_MEM;
    if (wrw && (wrd != '0) && (wrd == rs)) return FWD_WB;
    return FWD_NONE;
  endfunction

  assign o_forward_a = pick(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rs1);
  assign o_forward_b = pick(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rs2);

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control register chain (ID/EX -> EX/MEM -> MEM/WB) with load-use
// stall detection, taken-branch flush, operand forwarding and a saturating
// stall counter.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : pipe_ctrl_hazard_if.slave carrying id_* inputs, fetch-side
//           enables, stage register contents, forwarding selects, stall_count
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_ctrl_hazard_if.slave bus
);

  ctrl_t                 w_id_ctrl;
  logic                  w_load_use, w_branch, w_bubble, w_stall;
  fwd_e                  w_fwd_a, w_fwd_b;

  ctrl_t                 r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic                  r_mem_memread, r_mem_memwrite, r_mem_memtoreg, r_mem_regwrite;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_memtoreg, r_wb_regwrite;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [CNT_W-1:0]      r_stall_cnt;

  // Scrub decoded control so the pipe stays X-free.
  assign w_id_ctrl = '{
    aluop:    {x_to_zero(bus.id_aluop[1]), x_to_zero(bus.id_aluop[0])},
    alusrc:   x_to_zero(bus.id_alusrc),
    branch:   x_to_zero(bus.id_branch),
    memread:  x_to_zero(bus.id_memread),
    memwrite: x_to_zero(bus.id_memwrite),
    memtoreg: x_to_zero(bus.id_memtoreg),
    regwrite: x_to_zero(bus.id_regwrite)
  };

  // A load in EX whose destination is read by the instruction in ID.
  assign w_load_use = r_ex_ctrl.memread && (r_ex_rd != '0) &&
                      ((r_ex_rd == bus.id_rs1) || (r_ex_rd == bus.id_rs2));
  assign w_branch   = bus.ex_branch_taken;
  // Taken branch overrides a simultaneous load-use: the dependent instruction is flushed anyway.
  assign w_stall    = w_load_use && !w_branch;
  assign w_bubble   = w_load_use || w_branch;

  assign bus.pc_write   = !w_stall;
  assign bus.ifid_write = !w_stall;
  assign bus.ifid_flush = w_branch && !reset;

  // ID/EX: bubble on stall or flush, otherwise take the decoded instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_ctrl <= CTRL_BUBBLE;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_rd   <= '0;
    end else if (w_bubble) begin
      r_ex_ctrl <= CTRL_BUBBLE;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_rd   <= '0;
    end else begin
      r_ex_ctrl <= w_id_ctrl;
      r_ex_rs1  <= bus.id_rs1;
      r_ex_rs2  <= bus.id_rs2;
      r_ex_rd   <= bus.id_rd;
    end
  end

  // EX/MEM and MEM/WB always advance, carrying only the fields later stages use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= '0;
    end else begin
      r_mem_memread  <= r_ex_ctrl.memread;
      r_mem_memwrite <= r_ex_ctrl.memwrite;
      r_mem_memtoreg <= r_ex_ctrl.memtoreg;
      r_mem_regwrite <= r_ex_ctrl.regwrite;
      r_mem_rd       <= r_ex_rd;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_rd        <= r_mem_rd;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .i_mem_regwrite (r_mem_regwrite),
    .i_mem_rd       (r_mem_rd),
    .i_wb_regwrite  (r_wb_regwrite),
    .i_wb_rd        (r_wb_rd),
    .i_ex_rs1       (r_ex_rs1),
    .i_ex_rs2       (r_ex_rs2),
    .o_forward_a    (w_fwd_a),
    .o_forward_b    (w_fwd_b)
  );

  assign bus.ex_aluop     = r_ex_ctrl.aluop;
  assign bus.ex_alusrc    = r_ex_ctrl.alusrc;
  assign bus.ex_branch    = r_ex_ctrl.branch;
  assign bus.ex_memread   = r_ex_ctrl.memread;
  assign bus.ex_memwrite  = r_ex_ctrl.memwrite;
  assign bus.ex_memtoreg  = r_ex_ctrl.memtoreg;
  assign bus.ex_regwrite  = r_ex_ctrl.regwrite;
  assign bus.ex_rs1       = r_ex_rs1;
  assign bus.ex_rs2       = r_ex_rs2;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.mem_memread  = r_mem_memread;
  assign bus.mem_memwrite = r_mem_memwrite;
  assign bus.mem_memtoreg = r_mem_memtoreg;
  assign bus.mem_regwrite = r_mem_regwrite;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.wb_memtoreg  = r_wb_memtoreg;
  assign bus.wb_regwrite  = r_wb_regwrite;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.forward_a    = 2'(w_fwd_a);
  assign bus.forward_b    = 2'(w_fwd_b);
  assign bus.stall_count  = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl_hazard.md
PIPE_CTRL_HAZARD -- requirements
Module: pipe_ctrl_hazard

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clk and reset.
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoded control bits for the instruction in ID.
REQ-007 id_aluop  in  2  decoded ALU-operation class for the instruction in ID.
REQ-008 id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register fields of the instruction in ID.
REQ-009 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 pc_write, ifid_write, ifid_flush  out  1 each  fetch-side enables and flush.
REQ-011 ex_aluop (2), ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite (1 each), ex_rs1, ex_rs2, ex_rd (REG_ADDR_W each)  out  ID/EX register contents.
REQ-012 mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite (1 each), mem_rd (REG_ADDR_W)  out  EX/MEM register contents.
REQ-013 wb_memtoreg, wb_regwrite (1 each), wb_rd (REG_ADDR_W)  out  MEM/WB register contents.
REQ-014 forward_a, forward_b  out  2 each  ALU operand-source selects.
REQ-015 stall_count  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 ID/EX, EX/MEM and MEM/WB SHALL advance on every rising clk edge; no stage freezes.
REQ-017 Latency SHALL be exactly 1 cycle for ID inputs to ex_*, 2 cycles to mem_*, and 3 cycles to wb_*.
REQ-018 EX/MEM SHALL capture only memread, memwrite, memtoreg, regwrite and rd from ID/EX; MEM/WB SHALL capture only memtoreg, regwrite and rd from EX/MEM.
REQ-019 Any X on an id_* control input SHALL be captured as 0 (X-free pipeline).
REQ-020 load_use SHALL be combinational: ex_memread AND ex_rd != 0 AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
REQ-021 On load_use without ex_branch_taken: pc_write=0, ifid_write=0, ifid_flush=0, and ID/EX SHALL load a bubble (all control bits 0, rs1/rs2/rd 0).
REQ-022 On ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, ID/EX SHALL load a bubble, and EX/MEM SHALL capture the branch normally.
REQ-023 When ex_branch_taken and load_use are asserted together, the branch behaviour SHALL win and stall_count SHALL NOT increment.
REQ-024 Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, and ID/EX SHALL load the id_* inputs.
REQ-025 forward_a SHALL be 2'b10 if mem_regwrite AND mem_rd != 0 AND mem_rd == ex_rs1; else 2'b01 if wb_regwrite AND wb_rd != 0 AND wb_rd == ex_rs1; else 2'b00. forward_b SHALL follow the same rule using ex_rs2.
REQ-026 Register x0 SHALL never cause a stall or a forward.
REQ-027 stall_count SHALL increment by 1 on each edge where REQ-021 applies, and SHALL saturate at all-ones with no wrap.

Reset
REQ-028 Asserting reset SHALL clear all pipeline registers and stall_count to 0 immediately, without waiting for clk.
REQ-029 During reset, outputs SHALL be: pc_write=1, ifid_write=1, ifid_flush=0, forward_a/b=00, and all ex_*/mem_*/wb_* = 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight instructions; the first rising edge after deassertion SHALL load id_* into ID/EX.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold: struct ctrl_t (aluop, alusrc, branch, memread, memwrite, memtoreg, regwrite), constant CTRL_BUBBLE (all zeros), and enum fwd_e (FWD_NONE=00, FWD_WB=01, FWD_MEM=10).
REQ-032 Sub-module forward_unit (combinational, one instance) SHALL compute forward_a and forward_b; all remaining logic SHALL be in pipe_ctrl_hazard.

Verification
REQ-033 ld x5 (memread=1, regwrite=1, rd=5) followed by add with rs1=5 -> one cycle of pc_write=0, ifid_write=0, ex_* bubble; stall_count 0->1; next cycle forward_a=01.
REQ-034 Same sequence with rd=0 -> no stall; stall_count stays 0; forward_a=00.
REQ-035 add rd=3, add rd=3, then add rs1=3, rs2=3 -> forward_a=10 and forward_b=10 (MEM priority over WB).
REQ-036 ex_branch_taken=1 with load_use=1 in the same cycle -> ifid_flush=1, pc_write=1, ID/EX bubble, stall_count unchanged.
REQ-037 Force stall_count to 16'hFFFE and apply 3 load-use stalls -> stall_count reads FFFF and holds.
REQ-038 Assert reset mid-stream between edges -> all ex_*/mem_*/wb_* = 0 immediately; after deassertion, the id_* values appear on ex_* one edge later.
